// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, PC step and queue entry type for the fetch stage
package fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 64'd4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of {instr, pc} entries, no bypass
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_din    write i_din at the tail on the clock edge
//   i_pop            drop the head entry on the clock edge
//   i_flush          empty the queue (wins over push/pop)
//   o_count          number of stored entries (0..DEPTH)
//   o_valid, o_head  head entry and its valid flag
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_din,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_valid,
  output fetch_entry_t                 o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = i_pop & (count != '0);
  // A full queue only accepts a write when the head leaves in the same cycle.
  assign do_push = i_push & ((count != CW'(DEPTH)) | do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

  assign o_count = count;
  assign o_valid = (count != '0);
  assign o_head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 instruction fetch: PC, 1-cycle imem requests, redirect and decode handshake
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   o_imem_en, o_imem_addr        word read request to instruction memory
//   i_imem_rdata                  read data, valid the cycle after o_imem_en
//   i_redirect, i_redirect_pc     flush and restart fetch at the target
//   o_valid, o_instr, o_pc        queue head presented to decode
//   i_ready                       decode accepts head when o_valid & i_ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_en,
  output logic [XLEN-1:0]  o_imem_addr,
  input  logic [ILEN-1:0]  i_imem_rdata,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  output logic             o_valid,
  output logic [ILEN-1:0]  o_instr,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_ready
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight;

  logic [CW-1:0]   q_count;
  logic            q_valid;
  fetch_entry_t    q_head;
  fetch_entry_t    q_din;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic            unused_redirect_lo;

  assign pop  = q_valid & i_ready;
  // The response landing in a redirect cycle belongs to the old path.
  assign push = inflight & ~i_redirect;

  // Slots already promised (stored + in flight), less the one leaving now.
  // pop implies q_count >= 1, so this never underflows.
  assign occupancy = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = ~i_rst & ~i_redirect & (occupancy < (CW+1)'(QDEPTH));

  assign o_imem_en   = issue;
  assign o_imem_addr = pc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      if (i_redirect)  pc_q <= align_pc(i_redirect_pc);
      else if (issue)  pc_q <= pc_q + PC_INC;
      if (issue)       req_pc_q <= pc_q;
      inflight <= issue;
    end
  end

  assign q_din = '{instr: i_imem_rdata, pc: req_pc_q};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_din   (q_din),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .o_count (q_count),
    .o_valid (q_valid),
    .o_head  (q_head)
  );

  assign o_valid = q_valid;
  assign o_instr = q_head.instr;
  assign o_pc    = q_head.pc;

  assign unused_redirect_lo = ^i_redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized-ready bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        ready;

  bit nop_mode;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_en     (imem_en),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .o_instr       (instr),
    .o_pc          (pc),
    .i_ready       (ready)
  );

  function automatic logic [31:0] memword(input logic [63:0] a, input bit nop);
    if (nop) return 32'h0000_0013;
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  // Synchronous memory, one cycle latency; garbage when not read.
  always @(posedge clk) imem_rdata <= imem_en ? memword(imem_addr, nop_mode) : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in C0: the first cycle with i_rst low after reset.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", valid); end
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %0b want 0", imem_en); end
    vectors++; if (imem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  // C0..C3 with NOP memory and i_ready=1.
  task automatic test_stream();
    nop_mode = 1'b1;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      #1;
      vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'(c*4)) begin miscompares++; $display("FAIL stream_req C%0d: got en=%0b addr=%h want en=1 addr=%h", c, imem_en, imem_addr, 64'(c*4)); end
      vectors++; if (valid !== (c >= 2)) begin miscompares++; $display("FAIL stream_valid C%0d: got %0b want %0b", c, valid, (c >= 2)); end
      if (c >= 2) begin
        vectors++; if (pc !== 64'((c-2)*4) || instr !== 32'h13) begin miscompares++; $display("FAIL stream_head C%0d: got pc=%h instr=%h want pc=%h instr=00000013", c, pc, instr, 64'((c-2)*4)); end
      end
    end
  endtask

  // Continues from C3: head pc=0x8 in C4, held for 5 cycles.
  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      tick();
      ready = 1'b0;
      #1;
      vectors++; if (valid !== 1'b1 || pc !== 64'h8 || instr !== 32'h13) begin miscompares++; $display("FAIL hold_head k=%0d: got v=%0b pc=%h instr=%h want v=1 pc=8 instr=00000013", k, valid, pc, instr); end
      vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL hold_en k=%0d: got %0b want 0", k, imem_en); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      ready = 1'b1;
      #1;
      vectors++; if (valid !== 1'b1 || pc !== 64'(8 + 4*k)) begin miscompares++; $display("FAIL release_pc k=%0d: got v=%0b pc=%h want v=1 pc=%h", k, valid, pc, 64'(8 + 4*k)); end
      vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'(16 + 4*k)) begin miscompares++; $display("FAIL release_req k=%0d: got en=%0b addr=%h want en=1 addr=%h", k, imem_en, imem_addr, 64'(16 + 4*k)); end
    end
  endtask

  task automatic test_redirect();
    nop_mode = 1'b0;
    do_reset();
    ready = 1'b1;
    tick(); tick(); tick();
    // t: one queued word (pc 8) plus one in flight (pc C)
    tick();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h1000;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL redir_t_en: got %0b want 0", imem_en); end
    tick();
    redirect = 1'b0; ready = 1'b1;
    #1;
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'h1000) begin miscompares++; $display("FAIL redir_t1_req: got en=%0b addr=%h want en=1 addr=1000", imem_en, imem_addr); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL redir_t1_valid: got %0b want 0", valid); end
    tick(); #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL redir_t2_valid: got %0b pc=%h want 0", valid, pc); end
    tick(); #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h1000 || instr !== memword(64'h1000, 1'b0)) begin miscompares++; $display("FAIL redir_t3_head: got v=%0b pc=%h instr=%h want v=1 pc=1000 instr=%h", valid, pc, instr, memword(64'h1000, 1'b0)); end
    // unaligned target
    tick();
    redirect = 1'b1; redirect_pc = 64'h2003;
    #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h1004) begin miscompares++; $display("FAIL redir2_t_head: got v=%0b pc=%h want v=1 pc=1004", valid, pc); end
    tick();
    redirect = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'h2000) begin miscompares++; $display("FAIL redir2_req: got en=%0b addr=%h want en=1 addr=2000", imem_en, imem_addr); end
    tick(); #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL redir2_t2_valid: got %0b pc=%h want 0", valid, pc); end
    tick(); #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h2000 || instr !== memword(64'h2000, 1'b0)) begin miscompares++; $display("FAIL redir2_head: got v=%0b pc=%h instr=%h want v=1 pc=2000", valid, pc, instr); end
  endtask

  task automatic test_back_to_back();
    tick();
    redirect = 1'b1; redirect_pc = 64'h100;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL b2b_first_en: got %0b want 0", imem_en); end
    tick();
    redirect_pc = 64'h200;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL b2b_second_en: got %0b want 0", imem_en); end
    tick();
    redirect = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'h200) begin miscompares++; $display("FAIL b2b_req: got en=%0b addr=%h want en=1 addr=200", imem_en, imem_addr); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid1: got %0b want 0", valid); end
    tick(); #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid2: got %0b pc=%h want 0", valid, pc); end
    tick(); #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h200 || instr !== memword(64'h200, 1'b0)) begin miscompares++; $display("FAIL b2b_head: got v=%0b pc=%h instr=%h want v=1 pc=200", valid, pc, instr); end
    tick(); #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h204) begin miscompares++; $display("FAIL b2b_next: got v=%0b pc=%h want v=1 pc=204", valid, pc); end
  endtask

  task automatic test_reset_midstream();
    nop_mode = 1'b0;
    do_reset();
    ready = 1'b0;
    tick(); tick(); tick();
    #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h0) begin miscompares++; $display("FAIL mid_full_head: got v=%0b pc=%h want v=1 pc=0", valid, pc); end
    rst = 1'b1;
    #1;
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en: got %0b want 0", imem_en); end
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_after_valid: got %0b want 0", valid); end
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 64'h0) begin miscompares++; $display("FAIL mid_restart_req: got en=%0b addr=%h want en=1 addr=0", imem_en, imem_addr); end
    // reset while a request is in flight: its response must not appear
    do_reset();
    ready = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL inflight_rst_c0: got %0b want 0", valid); end
    tick(); #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL inflight_rst_c1: got v=%0b pc=%h instr=%h want 0", valid, pc, instr); end
    tick(); #1;
    vectors++; if (valid !== 1'b1 || pc !== 64'h0 || instr !== memword(64'h0, 1'b0)) begin miscompares++; $display("FAIL inflight_rst_c2: got v=%0b pc=%h instr=%h want v=1 pc=0", valid, pc, instr); end
  endtask

  task automatic test_random_ready();
    logic [63:0] exp_pc;
    logic [63:0] held_pc;
    bit          hold;
    int          delivered;
    nop_mode = 1'b0;
    do_reset();
    exp_pc = 64'h0; hold = 1'b0; held_pc = '0; delivered = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i > 0) tick();
      ready = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        vectors++; if (valid !== 1'b1 || pc !== held_pc) begin miscompares++; $display("FAIL rand_hold cyc=%0d: got v=%0b pc=%h want v=1 pc=%h", i, valid, pc, held_pc); end
      end
      if (valid && ready) begin
        vectors++; if (pc !== exp_pc || instr !== memword(exp_pc, 1'b0)) begin miscompares++; $display("FAIL rand_deliver cyc=%0d: got pc=%h instr=%h want pc=%h instr=%h", i, pc, instr, exp_pc, memword(exp_pc, 1'b0)); end
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      hold = valid & ~ready;
      held_pc = pc;
    end
    vectors++; if (delivered < 200) begin miscompares++; $display("FAIL rand_throughput: got %0d delivered want >=200", delivered); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0; nop_mode = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_reset_midstream();
    test_random_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
